// File: rtl/matrix_slot_writer_if.sv
// Write-request, element-stream and BRAM write-port signals of matrix_slot_writer.
// The requester/driver side uses the master modport and the writer uses the slave modport.
interface matrix_slot_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  // Handshakes: write_request is accepted on a rising edge where write_request && write_ready.
  // An element is transferred on a rising edge where write_data_valid && writer_ready.
  // The requester holds its request and its element until the transfer happens.
  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            write_matrix_id;
  logic [7:0]            write_rows;
  logic [7:0]            write_cols;
  logic [0:7][7:0]       write_name;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_data_valid;
  logic                  writer_ready;
  logic                  write_done;
  logic                  write_error;
  logic                  bram_wr_en;
  logic [ADDR_WIDTH-1:0] bram_wr_addr;
  logic [DATA_WIDTH-1:0] bram_wr_data;

  modport master (
    output write_request, write_matrix_id, write_rows, write_cols, write_name,
    output write_data, write_data_valid,
    input  write_ready, writer_ready, write_done, write_error,
    input  bram_wr_en, bram_wr_addr, bram_wr_data
  );

  modport slave (
    input  write_request, write_matrix_id, write_rows, write_cols, write_name,
    input  write_data, write_data_valid,
    output write_ready, writer_ready, write_done, write_error,
    output bram_wr_en, bram_wr_addr, bram_wr_data
  );
endinterface

// File: rtl/matrix_slot_writer.sv
// Stores one result matrix (3-word header + row-major data) into BRAM slot id*BLOCK_SIZE.
// Define MSW_TIMEOUT_EN to abort a write after TIMEOUT cycles without an accepted element.
module matrix_slot_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_SLOTS  = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  matrix_slot_writer_if.slave          bus,
  output logic [2:0]                   dbg_state_o,
  output logic [$clog2(TIMEOUT+1)-1:0] dbg_stall_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]           LIMIT = 16'(BLOCK_SIZE - 3);
  localparam logic [ADDR_WIDTH-1:0] BS    = ADDR_WIDTH'(BLOCK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR0, S_HDR1, S_HDR2, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t                state_q;
  logic [2:0]            id_q;
  logic [7:0]            rows_q, cols_q;
  logic [0:7][7:0]       name_q;
  logic [15:0]           total_q, idx_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [TW-1:0]         stall_q;
  logic                  ready_q, wready_q, done_q, err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [15:0]           prod_d;
  logic [ADDR_WIDTH-1:0] base_d;
  logic                  bad_d, accept_d, last_d;

  always_comb begin
    prod_d   = 16'(rows_q) * 16'(cols_q);
    base_d   = ADDR_WIDTH'(id_q) * BS;
    bad_d    = (rows_q == 8'd0) || (cols_q == 8'd0) ||
               (32'(id_q) >= 32'(NUM_SLOTS)) || (prod_d > LIMIT);
    accept_d = (state_q == S_DATA) && wready_q && bus.write_data_valid;
    last_d   = (idx_q == total_q - 16'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      name_q    <= '0;
      total_q   <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      stall_q   <= '0;
      ready_q   <= 1'b1;
      wready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.write_request && ready_q) begin
            id_q    <= bus.write_matrix_id;
            rows_q  <= bus.write_rows;
            cols_q  <= bus.write_cols;
            name_q  <= bus.write_name;
            ready_q <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          total_q <= prod_d;
          base_q  <= base_d;
          idx_q   <= '0;
          stall_q <= '0;
          if (bad_d) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_d;
            wr_data_q <= DATA_WIDTH'({rows_q, cols_q, 16'd0});
            state_q   <= S_HDR0;
          end
        end
        S_HDR0: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= base_q + ADDR_WIDTH'(1);
          wr_data_q <= DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
          state_q   <= S_HDR1;
        end
        S_HDR1: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= base_q + ADDR_WIDTH'(2);
          wr_data_q <= DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
          state_q   <= S_HDR2;
        end
        S_HDR2: begin
          wready_q <= 1'b1;
          state_q  <= S_DATA;
        end
        S_DATA: begin
          if (accept_d) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(idx_q);
            wr_data_q <= bus.write_data;
            idx_q     <= idx_q + 16'd1;
            stall_q   <= '0;
            if (last_d) wready_q <= 1'b0;
          end else if (!wready_q) begin
            // Last element went out on the previous edge; its write is on the bus now.
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
`ifdef MSW_TIMEOUT_EN
            if (stall_q == TW'(TIMEOUT - 1)) begin
              wready_q <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              state_q  <= S_ERR;
            end else begin
              stall_q <= stall_q + TW'(1);
            end
`else
            if (stall_q != TW'(TIMEOUT)) stall_q <= stall_q + TW'(1);
`endif
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q  <= 1'b1;
          wready_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.write_ready  = ready_q;
  assign bus.writer_ready = wready_q;
  assign bus.write_done   = done_q;
  assign bus.write_error  = err_q;
  assign bus.bram_wr_en   = wr_en_q;
  assign bus.bram_wr_addr = wr_addr_q;
  assign bus.bram_wr_data = wr_data_q;
  assign dbg_state_o      = state_q;
  assign dbg_stall_o      = stall_q;
endmodule

// File: tb/tb_matrix_slot_writer.sv
// Directed bench for matrix_slot_writer: expected BRAM writes queue, done/error latency checks.
module tb_matrix_slot_writer;
  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int TMO = 16;
  localparam int TW  = $clog2(TMO + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_slot_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [2:0]    dbg_state;
  logic [TW-1:0] dbg_stall;

  matrix_slot_writer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dbg_state_o(dbg_state), .dbg_stall_o(dbg_stall)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  logic [AW-1:0] last_addr = '0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int addr, input logic [DW-1:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  // Scoreboard: every BRAM strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bram_wr_en) begin
        logic [AW+DW-1:0] e;
        logic has;
        has = (exp_q.size() != 0);
        chk("wr_expected", 64'(has), 64'(1));
        if (has) begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.bram_wr_addr), 64'(e[AW+DW-1:DW]));
          chk("wr_data", 64'(bus.bram_wr_data), 64'(e[DW-1:0]));
        end
        last_addr = bus.bram_wr_addr;
      end
      if (bus.write_done) done_cnt++;
      if (bus.write_error) err_cnt++;
    end
  end

  task automatic request(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols,
                         input logic [63:0] name);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.write_matrix_id = id;
    bus.write_rows      = rows;
    bus.write_cols      = cols;
    bus.write_name      = name;
    bus.write_request   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.write_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accept", 64'(ok), 64'(1));
    @(posedge clk); #1;
    bus.write_request = 1'b0;
  endtask

  task automatic send_elem(input logic [DW-1:0] data, input int gap);
    logic ok;
    ok = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.write_data       = data;
    bus.write_data_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.writer_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("elem_accept", 64'(ok), 64'(1));
    @(posedge clk); #1;
    bus.write_data_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n, output logic err);
    logic seen;
    seen = 1'b0;
    err  = 1'b0;
    n    = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (bus.write_done) begin
        seen = 1'b1;
        err  = bus.write_error;
        n    = k;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
  endtask

  int   n;
  logic err;

  initial begin
    bus.write_request    = 1'b0;
    bus.write_matrix_id  = '0;
    bus.write_rows       = '0;
    bus.write_cols       = '0;
    bus.write_name       = '0;
    bus.write_data       = '0;
    bus.write_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write_ready", 64'(bus.write_ready), 64'(1));
    chk("rst_writer_ready", 64'(bus.writer_ready), 64'(0));
    chk("rst_done", 64'(bus.write_done), 64'(0));
    chk("rst_error", 64'(bus.write_error), 64'(0));
    chk("rst_wr_en", 64'(bus.bram_wr_en), 64'(0));
    chk("rst_wr_addr", 64'(bus.bram_wr_addr), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    chk("rst_stall", 64'(dbg_stall), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2x2 into slot 1
    push(1152, 32'h0202_0000); push(1153, 32'h5245_5355); push(1154, 32'h4C54_3031);
    push(1155, 32'd10); push(1156, 32'd20); push(1157, 32'd30); push(1158, 32'd40);
    request(3'd1, 8'd2, 8'd2, "RESULT01");
    chk("ready_drop", 64'(bus.write_ready), 64'(0));
    send_elem(32'd10, 0); send_elem(32'd20, 0); send_elem(32'd30, 0); send_elem(32'd40, 0);
    wait_done(50, n, err);
    exp_done++;
    chk("t1_done_lat", 64'(n), 64'(2));
    chk("t1_error", 64'(err), 64'(0));
    @(negedge clk);
    chk("t1_ready_back", 64'(bus.write_ready), 64'(1));
    chk("t1_writer_ready", 64'(bus.writer_ready), 64'(0));
    chk("t1_q_drained", 64'(exp_q.size()), 64'(0));

    // zero rows rejected two cycles after accept
    request(3'd2, 8'd0, 8'd3, "ZEROROWS");
    wait_done(50, n, err);
    exp_done++; exp_err++;
    chk("t2_err_lat", 64'(n), 64'(2));
    chk("t2_error", 64'(err), 64'(1));

    // 32x36 exceeds the slot, 31x37 fills it
    request(3'd1, 8'd32, 8'd36, "TOOBIG!!");
    wait_done(50, n, err);
    exp_done++; exp_err++;
    chk("t3_reject", 64'(err), 64'(1));
    push(1152, 32'h1F25_0000); push(1153, 32'h4D41_5452); push(1154, 32'h4958_3331);
    for (int i = 0; i < 1147; i++) push(1155 + i, 32'h1000_0000 + 32'(i));
    request(3'd1, 8'd31, 8'd37, "MATRIX31");
    for (int i = 0; i < 1147; i++) send_elem(32'h1000_0000 + 32'(i), 0);
    wait_done(50, n, err);
    exp_done++;
    chk("t3_full_error", 64'(err), 64'(0));
    chk("t3_last_addr", 64'(last_addr), 64'(2301));

    // 3x1 with stalls between elements
    push(3456, 32'h0301_0000); push(3457, 32'h434F_4C33); push(3458, 32'h5831_5F5F);
    push(3459, 32'h0A); push(3460, 32'h0B); push(3461, 32'h0C);
    request(3'd3, 8'd3, 8'd1, "COL3X1__");
    send_elem(32'h0A, 0); send_elem(32'h0B, 5); send_elem(32'h0C, 17);
    wait_done(50, n, err);
    exp_done++;
    chk("t4_done_lat", 64'(n), 64'(2));
    chk("t4_error", 64'(err), 64'(0));

    // request held during DATA of a prior write is served only after it
    push(0, 32'h0102_0000); push(1, 32'h4141_4141); push(2, 32'h4141_4141);
    push(3, 32'h111); push(4, 32'h222);
    push(4608, 32'h0101_0000); push(4609, 32'h4242_4242); push(4610, 32'h4242_4242);
    push(4611, 32'h333);
    request(3'd0, 8'd1, 8'd2, "AAAAAAAA");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.writer_ready) break;
    end
    bus.write_matrix_id = 3'd4;
    bus.write_rows      = 8'd1;
    bus.write_cols      = 8'd1;
    bus.write_name      = "BBBBBBBB";
    bus.write_request   = 1'b1;
    chk("t5_ready_in_data", 64'(bus.write_ready), 64'(0));
    send_elem(32'h111, 3); send_elem(32'h222, 2);
    wait_done(50, n, err);
    exp_done++;
    chk("t5a_done_lat", 64'(n), 64'(2));
    request(3'd4, 8'd1, 8'd1, "BBBBBBBB");
    send_elem(32'h333, 0);
    wait_done(50, n, err);
    exp_done++;
    chk("t5b_error", 64'(err), 64'(0));

    // reset in the middle of DATA
    push(5760, 32'h0202_0000); push(5761, 32'h5245_5345); push(5762, 32'h544D_4521);
    push(5763, 32'h55);
    request(3'd5, 8'd2, 8'd2, "RESETME!");
    send_elem(32'h55, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write_ready", 64'(bus.write_ready), 64'(1));
    chk("mid_rst_writer_ready", 64'(bus.writer_ready), 64'(0));
    chk("mid_rst_done", 64'(bus.write_done), 64'(0));
    chk("mid_rst_wr_en", 64'(bus.bram_wr_en), 64'(0));
    chk("mid_rst_wr_addr", 64'(bus.bram_wr_addr), 64'(0));
    chk("mid_rst_wr_data", 64'(bus.bram_wr_data), 64'(0));
    chk("mid_rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef MSW_TIMEOUT_EN
    push(6912, 32'h0202_0000); push(6913, 32'h5449_4D45); push(6914, 32'h4F55_5421);
    push(6915, 32'd1); push(6916, 32'd2);
    request(3'd6, 8'd2, 8'd2, "TIMEOUT!");
    send_elem(32'd1, 0); send_elem(32'd2, 0);
    wait_done(100, n, err);
    exp_done++; exp_err++;
    chk("t7_timeout_lat", 64'(n), 64'(16));
    chk("t7_timeout_err", 64'(err), 64'(1));
`endif

    repeat (5) @(negedge clk);
    chk("final_q_empty", 64'(exp_q.size()), 64'(0));
    chk("final_done_cnt", 64'(done_cnt), 64'(exp_done));
    chk("final_err_cnt", 64'(err_cnt), 64'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
